lsq_mem_responder: RTL and testbench



---
 rtl/lsq_mem_responder.sv | 143 ++++++++++++++
 tb/tb_lsq_mem_responder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsq_mem_responder.sv
// lsq_mem_responder: single-outstanding load/store responder for the LSQ.
// Accepts one request, waits LATENCY cycles, accesses an internal word array
// and returns a tagged response held until the queue takes it.
// Optional: define LSQ_MEM_ERR_EN to flag misaligned / out-of-range requests
// on resp_err; otherwise addresses wrap modulo DEPTH_WORDS words.
module lsq_mem_responder #(
  parameter int MEM_ADDR_WIDTH = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH_WORDS    = 1024,
  parameter int TAG_WIDTH      = 7,
  parameter int LATENCY        = 2
) (
  input  logic                      clk,
  input  logic                      sync_rst,
  input  logic                      clk_en,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_load_store,
  input  logic [MEM_ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]     req_data,
  input  logic [TAG_WIDTH-1:0]      req_tag,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic                      resp_load_store,
  output logic [TAG_WIDTH-1:0]      resp_tag,
  output logic [DATA_WIDTH-1:0]     resp_data,
  output logic                      resp_err
);

  localparam int OFF = $clog2(DATA_WIDTH / 8);
  localparam int IW  = $clog2(DEPTH_WORDS);
  localparam int CW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

  state_t                r_state, w_next;
  logic [CW-1:0]         r_cnt;
  logic                  r_ls;
  logic [IW-1:0]         r_idx;
  logic [DATA_WIDTH-1:0] r_data;
  logic [TAG_WIDTH-1:0]  r_tag;
  logic                  r_fault;

  logic                  r_resp_valid;
  logic                  r_resp_ls;
  logic [TAG_WIDTH-1:0]  r_resp_tag;
  logic [DATA_WIDTH-1:0] r_resp_data;
  logic                  r_resp_err;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

  logic [IW-1:0]         w_idx;
  logic                  w_fault;
  logic                  w_accept;
  logic                  w_access;

  assign w_idx = req_addr[IW+OFF-1:OFF];

`ifdef LSQ_MEM_ERR_EN
  // Fault on any low offset bit or any address bit above the word index.
  assign w_fault = (|req_addr[OFF-1:0]) || (|req_addr[MEM_ADDR_WIDTH-1:IW+OFF]);
`else
  // Offset and upper bits are intentionally dropped: addresses wrap.
  logic w_unused_addr;
  assign w_unused_addr = ^{req_addr[MEM_ADDR_WIDTH-1:IW+OFF], req_addr[OFF-1:0]};
  assign w_fault       = 1'b0;
`endif

  assign req_ready = (r_state == IDLE) && clk_en && !sync_rst;
  assign w_accept  = req_valid && req_ready;
  // Access edge: last ACCESS cycle on an enabled, non-reset edge.
  assign w_access  = (r_state == ACCESS) && (r_cnt == '0) && clk_en && !sync_rst;

  assign resp_valid      = r_resp_valid;
  assign resp_load_store = r_resp_ls;
  assign resp_tag        = r_resp_tag;
  assign resp_data       = r_resp_data;
  assign resp_err        = r_resp_err;

  // State register; clk_en low freezes it.
  always_ff @(posedge clk) begin
    if (sync_rst)    r_state <= IDLE;
    else if (clk_en) r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept)       w_next = ACCESS;
      ACCESS:  if (r_cnt == '0)    w_next = RESPOND;
      RESPOND: if (resp_ready)     w_next = IDLE;
      default:                     w_next = IDLE;
    endcase
  end

  // Request latch, latency counter and registered response fields.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      r_cnt        <= '0;
      r_ls         <= 1'b0;
      r_idx        <= '0;
      r_data       <= '0;
      r_tag        <= '0;
      r_fault      <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_ls    <= 1'b0;
      r_resp_tag   <= '0;
      r_resp_data  <= '0;
      r_resp_err   <= 1'b0;
    end else if (clk_en) begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_ls    <= req_load_store;
          r_idx   <= w_idx;
          r_data  <= req_data;
          r_tag   <= req_tag;
          r_fault <= w_fault;
          r_cnt   <= CW'(LATENCY - 1);
        end
        ACCESS: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end else begin
            r_resp_valid <= 1'b1;
            r_resp_ls    <= r_ls;
            r_resp_tag   <= r_tag;
            r_resp_err   <= r_fault;
            r_resp_data  <= (r_ls || r_fault) ? '0 : r_mem[r_idx];
          end
        end
        RESPOND: if (resp_ready) r_resp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  // Array write; contents are never reset and faulting stores are dropped.
  always_ff @(posedge clk) begin
    if (w_access && r_ls && !r_fault) r_mem[r_idx] <= r_data;
  end

endmodule

// File: tb/tb_lsq_mem_responder.sv
// Directed bench for lsq_mem_responder (default parameters, LATENCY = 2).
module tb_lsq_mem_responder;

  logic        clk = 1'b0;
  logic        sync_rst, clk_en, req_valid, req_ready, req_load_store;
  logic [31:0] req_addr, req_data;
  logic [6:0]  req_tag;
  logic        resp_valid, resp_ready, resp_load_store, resp_err;
  logic [6:0]  resp_tag;
  logic [31:0] resp_data;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  lsq_mem_responder dut (
    .clk(clk), .sync_rst(sync_rst), .clk_en(clk_en),
    .req_valid(req_valid), .req_ready(req_ready), .req_load_store(req_load_store),
    .req_addr(req_addr), .req_data(req_data), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_load_store(resp_load_store),
    .resp_tag(resp_tag), .resp_data(resp_data), .resp_err(resp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Issue one request and wait for its response; lat = cycles from the
  // acceptance edge to resp_valid, or -1 on timeout. Leaves resp pending.
  task automatic run_req(input logic ls, input logic [31:0] addr,
                         input logic [31:0] data, input logic [6:0] tag,
                         output int lat);
    int n;
    lat = -1;
    n = 0;
    while (!req_ready && n < 20) begin step(); n++; end
    if (req_ready) begin
      req_valid = 1'b1; req_load_store = ls; req_addr = addr;
      req_data = data; req_tag = tag;
      step();
      req_valid = 1'b0;
      n = 0;
      while (!resp_valid && n < 20) begin step(); n++; end
      if (resp_valid) lat = n;
    end
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1; step(); resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    sync_rst = 1'b1; step(); step();
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", req_ready); end
    checks++;
    if ({resp_valid, resp_load_store, resp_err} !== 3'b000) begin
      errors++; $display("FAIL rst_flags: got %b want 000", {resp_valid, resp_load_store, resp_err});
    end
    checks++;
    if (resp_tag !== 7'd0 || resp_data !== 32'd0) begin
      errors++; $display("FAIL rst_fields: got tag %0d data %h want 0 0", resp_tag, resp_data);
    end
    sync_rst = 1'b0; #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_store_load();
    int lat;
    run_req(1'b1, 32'h10, 32'hDEADBEEF, 7'd5, lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL st_latency: got %0d want 2", lat); end
    checks++;
    if ({resp_tag, resp_load_store, resp_err} !== {7'd5, 1'b1, 1'b0} || resp_data !== 32'd0) begin
      errors++; $display("FAIL st_resp: got tag %0d ls %b err %b data %h want 5 1 0 0",
                         resp_tag, resp_load_store, resp_err, resp_data);
    end
    finish_resp();
    run_req(1'b0, 32'h10, 32'h0, 7'd6, lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL ld_latency: got %0d want 2", lat); end
    checks++;
    if ({resp_tag, resp_load_store, resp_err} !== {7'd6, 1'b0, 1'b0} || resp_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL ld_resp: got tag %0d ls %b err %b data %h want 6 0 0 deadbeef",
                         resp_tag, resp_load_store, resp_err, resp_data);
    end
    finish_resp();
  endtask

  task automatic test_resp_hold();
    int lat;
    run_req(1'b0, 32'h10, 32'h0, 7'd7, lat);
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({resp_valid, resp_tag, resp_data, req_ready} !== {1'b1, 7'd7, 32'hDEADBEEF, 1'b0}) begin
        errors++; $display("FAIL hold_stable: got v %b tag %0d data %h rdy %b want 1 7 deadbeef 0",
                           resp_valid, resp_tag, resp_data, req_ready);
      end
    end
    resp_ready = 1'b1; #1;
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL hold_ready_respond: got %b want 0", req_ready); end
    step(); resp_ready = 1'b0;
    checks++;
    if ({resp_valid, req_ready, resp_tag} !== {1'b0, 1'b1, 7'd7}) begin
      errors++; $display("FAIL hold_release: got v %b rdy %b tag %0d want 0 1 7", resp_valid, req_ready, resp_tag);
    end
  endtask

  task automatic test_clk_en();
    int n;
    req_valid = 1'b1; req_load_store = 1'b0; req_addr = 32'h10; req_tag = 7'd8;
    step();
    req_valid = 1'b0; clk_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({resp_valid, req_ready, resp_tag} !== {1'b0, 1'b0, 7'd7}) begin
        errors++; $display("FAIL clken_frozen: got v %b rdy %b tag %0d want 0 0 7", resp_valid, req_ready, resp_tag);
      end
    end
    clk_en = 1'b1;
    n = 0;
    while (!resp_valid && n < 20) begin step(); n++; end
    checks++;
    if (n + 3 !== 5 || resp_tag !== 7'd8) begin
      errors++; $display("FAIL clken_latency: got %0d tag %0d want 5 8", n + 3, resp_tag);
    end
    finish_resp();
  endtask

  task automatic test_sync_rst();
    int lat;
    logic seen;
    run_req(1'b1, 32'h20, 32'h0, 7'd1, lat);
    finish_resp();
    req_valid = 1'b1; req_load_store = 1'b1; req_addr = 32'h20;
    req_data = 32'h12345678; req_tag = 7'd2;
    step();
    req_valid = 1'b0;
    step();
    sync_rst = 1'b1;
    step();
    sync_rst = 1'b0;
    seen = resp_valid;
    for (int i = 0; i < 3; i++) begin step(); seen |= resp_valid; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL rst_drop: got resp_valid %b want 0", seen); end
    run_req(1'b0, 32'h20, 32'h0, 7'd3, lat);
    checks++;
    if (lat !== 2 || resp_tag !== 7'd3 || resp_data !== 32'h0) begin
      errors++; $display("FAIL rst_no_write: got lat %0d tag %0d data %h want 2 3 0", lat, resp_tag, resp_data);
    end
    finish_resp();
  endtask

`ifdef LSQ_MEM_ERR_EN
  task automatic test_err();
    int lat;
    run_req(1'b1, 32'h13, 32'hBB, 7'd30, lat);
    checks++;
    if (lat !== 2 || {resp_err, resp_load_store} !== 2'b11 || resp_data !== 32'h0) begin
      errors++; $display("FAIL err_misalign: got lat %0d err %b ls %b data %h want 2 1 1 0",
                         lat, resp_err, resp_load_store, resp_data);
    end
    finish_resp();
    run_req(1'b0, 32'h10, 32'h0, 7'd31, lat);
    checks++;
    if (resp_err !== 1'b0 || resp_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL err_unchanged: got err %b data %h want 0 deadbeef", resp_err, resp_data);
    end
    finish_resp();
    run_req(1'b0, 32'h1000, 32'h0, 7'd32, lat);
    checks++;
    if (lat !== 2 || resp_err !== 1'b1 || resp_data !== 32'h0) begin
      errors++; $display("FAIL err_range: got lat %0d err %b data %h want 2 1 0", lat, resp_err, resp_data);
    end
    finish_resp();
  endtask
`else
  task automatic test_wrap();
    int lat;
    run_req(1'b1, 32'h1000, 32'hAA, 7'd20, lat);
    checks++;
    if (lat !== 2 || resp_err !== 1'b0 || resp_tag !== 7'd20) begin
      errors++; $display("FAIL wrap_store: got lat %0d err %b tag %0d want 2 0 20", lat, resp_err, resp_tag);
    end
    finish_resp();
    run_req(1'b0, 32'h0, 32'h0, 7'd21, lat);
    checks++;
    if (resp_data !== 32'hAA || resp_err !== 1'b0) begin
      errors++; $display("FAIL wrap_load: got data %h err %b want aa 0", resp_data, resp_err);
    end
    finish_resp();
  endtask
`endif

  task automatic test_back_to_back();
    int acc[3];
    logic [6:0] rtag[3];
    int k, j;
    logic acc_now;
    acc = '{0, 0, 0};
    rtag = '{7'd0, 7'd0, 7'd0};
    k = 0; j = 0;
    resp_ready = 1'b1;
    req_valid = 1'b1; req_load_store = 1'b0; req_addr = 32'h10; req_tag = 7'd10;
    for (int n = 0; n < 60 && j < 3; n++) begin
      acc_now = req_valid && req_ready;
      if (acc_now) acc[k] = cyc;
      if (resp_valid) begin rtag[j] = resp_tag; j++; end
      step();
      if (acc_now) begin
        k++;
        if (k < 3) req_tag = 7'(10 + k);
        else       req_valid = 1'b0;
      end
    end
    req_valid = 1'b0; resp_ready = 1'b0;
    checks++;
    if (acc[1] - acc[0] !== 4 || acc[2] - acc[1] !== 4) begin
      errors++; $display("FAIL b2b_spacing: got %0d %0d want 4 4", acc[1] - acc[0], acc[2] - acc[1]);
    end
    checks++;
    if (j !== 3 || rtag[0] !== 7'd10 || rtag[1] !== 7'd11 || rtag[2] !== 7'd12) begin
      errors++; $display("FAIL b2b_tags: got n %0d tags %0d %0d %0d want 3 10 11 12", j, rtag[0], rtag[1], rtag[2]);
    end
  endtask

  initial begin
    sync_rst = 1'b1; clk_en = 1'b1; req_valid = 1'b0; req_load_store = 1'b0;
    req_addr = '0; req_data = '0; req_tag = '0; resp_ready = 1'b0;
    test_reset();
    test_store_load();
    test_resp_hold();
    test_clk_en();
    test_sync_rst();
`ifdef LSQ_MEM_ERR_EN
    test_err();
`else
    test_wrap();
`endif
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
